// File: rtl/ffs_result_buffer.sv
// Credit-managed elastic buffer behind the non-stallable FFS pipeline.
// Reserves a slot per issue, captures results into a circular FIFO, exposes valid/ready.
module ffs_result_buffer #(
  parameter int DEPTH    = 16,
  parameter int RESULT_W = 10,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                res_valid,
  input  logic [RESULT_W-1:0] res_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RESULT_W-1:0] m_data,
  output logic [CNT_W-1:0]    occupancy,
  output logic [CNT_W-1:0]    reserved,
  output logic [1:0]          err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [RESULT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    occ_q, res_q;
  logic [1:0]          err_q;
  logic                issue, pop, push;

  always_comb begin
    issue_ready = (res_q < DEPTH_C);
    m_valid     = (occ_q != '0);
    m_data      = mem[rd_ptr];
    occupancy   = occ_q;
    reserved    = res_q;
    err         = err_q;
  end

  // A full FIFO still accepts a beat when the head is popped in the same cycle.
  always_comb begin
    issue = issue_valid & issue_ready;
    pop   = m_valid & m_ready;
    push  = res_valid & ((occ_q < DEPTH_C) | pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      res_q  <= '0;
      err_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
      res_q <= res_q + CNT_W'(issue) - CNT_W'(pop);
      if (issue_valid & ~issue_ready) err_q[0] <= 1'b1;
      if (res_valid & ~push)          err_q[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_data;
  end

endmodule
